// File: rtl/mem_access.sv
// MEM-stage byte-serial load/store unit over an 8-bit RAM port.
// Optional alignment trap enabled by `define MEM_MISALIGN_CHECK_EN (adds misalign_err).
module mem_access #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mem_wd,
  input  logic              mem_wreg,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_sdata,
  input  logic              ram_busy,
  input  logic [7:0]        ram_din,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              stall_req,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic              misalign_err,
`endif
  output logic [31:0]       wb_wdata
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLh  = 4'd2;
  localparam logic [3:0] OpLw  = 4'd3;
  localparam logic [3:0] OpLbu = 4'd4;
  localparam logic [3:0] OpLhu = 4'd5;
  localparam logic [3:0] OpSb  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSw  = 4'd8;

  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    case (op)
      OpLb, OpLbu, OpSb: op_bytes = 3'd1;
      OpLh, OpLhu, OpSh: op_bytes = 3'd2;
      OpLw, OpSw:        op_bytes = 3'd4;
      default:           op_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    op_store = (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [2:0]        idx_q, idx_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic              pend_q, pend_d;
  logic              mis_q, mis_d;

  logic [2:0]  nbytes;
  logic        in_mem_op;
  logic        misalign;
  logic [31:0] asm_full;

  assign nbytes    = op_bytes(op_q);
  assign in_mem_op = (op_bytes(mem_op) != 3'd0);
  assign misalign  = (((mem_op == OpLh) || (mem_op == OpLhu) || (mem_op == OpSh)) && mem_addr[0])
                  || (((mem_op == OpLw) || (mem_op == OpSw)) && (mem_addr[1:0] != 2'b00));

  // Last load byte arrives in the DONE cycle itself, so it bypasses the assembly register.
  always_comb begin
    asm_full = asm_q;
    if (pend_q) asm_full[{cnt_q, 3'b000} +: 8] = ram_din;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    pend_d  = pend_q;
    mis_d   = mis_q;
    case (state_q)
      StIdle: begin
        if (in_mem_op) begin
          op_d    = mem_op;
          addr_d  = mem_addr;
          sdata_d = mem_sdata;
          wd_d    = mem_wd;
          wreg_d  = mem_wreg;
          idx_d   = 3'd0;
          cnt_d   = 2'd0;
          asm_d   = 32'd0;
          pend_d  = 1'b0;
          state_d = StAccess;
`ifdef MEM_MISALIGN_CHECK_EN
          if (misalign) begin
            mis_d   = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StAccess: begin
        pend_d = 1'b0;
        if (pend_q) begin
          asm_d[{cnt_q, 3'b000} +: 8] = ram_din;
          cnt_d = cnt_q + 2'd1;
        end
        if ((idx_q < nbytes) && !ram_busy) begin
          idx_d  = idx_q + 3'd1;
          pend_d = !op_store(op_q);
          if (idx_q == nbytes - 3'd1) state_d = StDone;
        end
      end
      StDone: begin
        pend_d  = 1'b0;
        mis_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_dout  = 8'd0;
    stall_req = 1'b0;
    wb_wd     = 5'd0;
    wb_wreg   = 1'b0;
    wb_wdata  = 32'd0;
`ifdef MEM_MISALIGN_CHECK_EN
    misalign_err = 1'b0;
`endif
    if (!rst) begin
      case (state_q)
        StIdle: begin
          if (in_mem_op) begin
            stall_req = 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_err = misalign;
`endif
          end else begin
            wb_wd    = mem_wd;
            wb_wreg  = mem_wreg;
            wb_wdata = mem_wdata;
          end
        end
        StAccess: begin
          stall_req = 1'b1;
          if (idx_q < nbytes) begin
            ram_req  = 1'b1;
            ram_we   = op_store(op_q);
            ram_addr = addr_q + ADDR_W'(idx_q);
            if (op_store(op_q)) ram_dout = sdata_q[{idx_q[1:0], 3'b000} +: 8];
          end
        end
        StDone: begin
          wb_wd = wd_q;
`ifdef MEM_MISALIGN_CHECK_EN
          misalign_err = mis_q;
`endif
          if (!op_store(op_q) && !mis_q) begin
            wb_wreg = wreg_q;
            case (op_q)
              OpLb:    wb_wdata = {{24{asm_full[7]}}, asm_full[7:0]};
              OpLh:    wb_wdata = {{16{asm_full[15]}}, asm_full[15:0]};
              OpLbu:   wb_wdata = {24'd0, asm_full[7:0]};
              OpLhu:   wb_wdata = {16'd0, asm_full[15:0]};
              default: wb_wdata = asm_full;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 4'd0;
      addr_q  <= '0;
      sdata_q <= 32'd0;
      wd_q    <= 5'd0;
      wreg_q  <= 1'b0;
      idx_q   <= 3'd0;
      cnt_q   <= 2'd0;
      asm_q   <= 32'd0;
      pend_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: the bench plays the RAM and predicts results from a byte map.
module tb_mem_access;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    mem_wd;
  logic          mem_wreg;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_sdata;
  logic          ram_busy;
  logic [7:0]    ram_din;
  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic          stall_req;
  logic [4:0]    wb_wd;
  logic          wb_wreg;
  logic [31:0]   wb_wdata;
`ifdef MEM_MISALIGN_CHECK_EN
  logic          misalign_err;
`endif

  mem_access #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata), .ram_busy(ram_busy),
    .ram_din(ram_din), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .stall_req(stall_req), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic int unsigned n_of(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < int'(n_of(op)); k++) v = v | (32'(rd_byte(a + 32'(k))) << (8 * k));
    if (op == 4'd1 && v[7])  v = v | 32'hFFFF_FF00;
    if (op == 4'd2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic passthrough(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                             input logic [31:0] wdata);
    @(posedge clk); #1;
    mem_op = op; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    mem_addr = 32'($urandom); mem_sdata = $urandom; ram_busy = 1'b0;
    @(negedge clk);
    check("pt_wd", 32'(wb_wd), 32'(wd));
    check("pt_wreg", 32'(wb_wreg), 32'(wreg));
    check("pt_wdata", wb_wdata, wdata);
    check("pt_stall", 32'(stall_req), 0);
    check("pt_req", 32'(ram_req), 0);
  endtask

  // busy_mode: 0 never busy, 1 random, 2 busy for two cycles on the second byte request
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] wd, input logic wreg, input int busy_mode,
                        output logic [31:0] wb_seen);
    int unsigned n = n_of(op);
    bit          store = (op >= 4'd6);
    int          k = 0, busy_cnt = 0, cyc = 0;
    bit          rd_pend = 0, done = 0;
    logic [31:0] rd_addr = 32'd0;
    wb_seen = 32'd0;
    @(posedge clk); #1;
    mem_op = op; mem_addr = a; mem_sdata = sd; mem_wd = wd; mem_wreg = wreg;
    mem_wdata = $urandom; ram_busy = 1'b0;
    @(negedge clk);
    check("start_stall", 32'(stall_req), 1);
    check("start_req", 32'(ram_req), 0);
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      ram_din = rd_pend ? rd_byte(rd_addr) : 8'($urandom);
      rd_pend = 0;
      case (busy_mode)
        0:       ram_busy = 1'b0;
        1:       ram_busy = ($urandom_range(0, 2) == 0);
        default: ram_busy = (k == 1 && busy_cnt < 2);
      endcase
      @(negedge clk);
      if (!stall_req) begin
        done = 1;
        check("latency", 32'(cyc), 32'(n + 1 + busy_cnt));
        check("nbytes", 32'(k), 32'(n));
        check("done_req", 32'(ram_req), 0);
        check("done_wd", 32'(wb_wd), 32'(wd));
        check("done_wreg", 32'(wb_wreg), store ? 0 : 32'(wreg));
        check("done_wdata", wb_wdata, store ? 32'd0 : ref_load(op, a));
        wb_seen = wb_wdata;
      end else if (cyc > 40) begin
        done = 1;
        check("timeout", 0, 1);
      end else begin
        check("acc_wreg", 32'(wb_wreg), 0);
        if (ram_req) begin
          check("addr", ram_addr, a + 32'(k));
          check("we", 32'(ram_we), 32'(store));
          if (store) check("dout", 32'(ram_dout), 32'(sd[8 * (k % 4) +: 8]));
          if (!ram_busy) begin
            if (store) mem[a + 32'(k)] = sd[8 * (k % 4) +: 8];
            else begin
              rd_pend = 1;
              rd_addr = a + 32'(k);
            end
            k++;
          end else busy_cnt++;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] seen;
    logic [3:0]  op;
    logic [31:0] a;
    rst = 1'b1; mem_op = 4'd0; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'hDEAD_BEEF;
    mem_addr = 32'd0; mem_sdata = 32'd0; ram_busy = 1'b0; ram_din = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wdata", wb_wdata, 0);
    check("rst_wreg", 32'(wb_wreg), 0);
    check("rst_wd", 32'(wb_wd), 0);
    check("rst_stall", 32'(stall_req), 0);
    check("rst_req", 32'(ram_req), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    passthrough(4'd0, 5'd5, 1'b1, 32'hDEAD_BEEF);
    passthrough(4'd12, 5'd17, 1'b0, 32'h1234_5678);

    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    run_op(4'd3, 32'h100, 32'd0, 5'd3, 1'b1, 0, seen);
    check("lw_value", seen, 32'h4433_2211);
    mem[32'h200] = 8'h80;
    run_op(4'd1, 32'h200, 32'd0, 5'd4, 1'b1, 0, seen);
    check("lb_value", seen, 32'hFFFF_FF80);
    run_op(4'd4, 32'h200, 32'd0, 5'd4, 1'b1, 0, seen);
    check("lbu_value", seen, 32'h0000_0080);
`ifndef MEM_MISALIGN_CHECK_EN
    run_op(4'd7, 32'h301, 32'hABCD_1234, 5'd6, 1'b1, 0, seen);
    check("sh_mem0", 32'(mem[32'h301]), 32'h34);
    check("sh_mem1", 32'(mem[32'h302]), 32'h12);
`endif
    run_op(4'd3, 32'h100, 32'd0, 5'd3, 1'b1, 2, seen);
    check("lw_busy_value", seen, 32'h4433_2211);

    // Reset in the middle of a word load
    @(posedge clk); #1;
    mem_op = 4'd3; mem_addr = 32'h100; mem_wd = 5'd9; mem_wreg = 1'b1; ram_busy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", 32'(ram_req), 0);
    check("mid_rst_stall", 32'(stall_req), 0);
    @(posedge clk); #1;
    rst = 1'b0; mem_op = 4'd0; mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
    @(negedge clk);
    check("post_rst_req", 32'(ram_req), 0);
    check("post_rst_stall", 32'(stall_req), 0);
    check("post_rst_wd", 32'(wb_wd), 0);
    check("post_rst_wreg", 32'(wb_wreg), 0);
    check("post_rst_wdata", wb_wdata, 0);
    run_op(4'd6, 32'h400, 32'h0000_005A, 5'd2, 1'b0, 0, seen);
    check("sb_mem", 32'(mem[32'h400]), 32'h5A);

    for (int t = 0; t < 60; t++) begin
      op = 4'($urandom_range(0, 15));
      a  = 32'h1000 + $urandom_range(0, 31);
      if (t == 30) a = 32'hFFFF_FFFE;
`ifdef MEM_MISALIGN_CHECK_EN
      a = a & 32'hFFFF_FFFC;
`endif
      if (n_of(op) == 0) passthrough(op, 5'($urandom), 1'($urandom), $urandom);
      else run_op(op, a, $urandom, 5'($urandom), 1'($urandom), 1, seen);
    end

    @(posedge clk); #1;
    mem_op = 4'd0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
